// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor, BITS_PER_CYCLE bits per clock
//   with a registered ripple carry between chunks.
// Latency: start sampled at edge k -> done pulses in the cycle after edge k+N,
//   N = WIDTH/BITS_PER_CYCLE.
// Backpressure: start is ignored while busy; a start during the done cycle is
//   accepted, so back-to-back operations have a single-cycle bubble.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, sub        request and operation select (0 = a+b+cin, 1 = a-b)
//   a, b, cin         operands and carry-in, sampled with an accepted start
//   busy, done        busy while running; one-cycle done pulse on completion
//   sum, cout         result and final carry (for subtract, 1 = no borrow)
//   ovf               signed overflow, present only when SERIAL_ADDER_OVF_EN
//                     is defined
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = (BITS_PER_CYCLE > 0) ? (WIDTH / BITS_PER_CYCLE) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("serial_adder: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic [WIDTH-1:0]            a_q;
  logic [WIDTH-1:0]            b_q;
  logic                        carry;
  logic [CW-1:0]               cnt;
  logic [WIDTH-1:0]            res_q;

  logic [BITS_PER_CYCLE:0]     chunk;
  logic [WIDTH-1:0]            res_next;

  always_comb begin
    chunk = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
          + {1'b0, b_q[BITS_PER_CYCLE-1:0]}
          + {{BITS_PER_CYCLE{1'b0}}, carry};
    // New chunk enters at the MSB end; after N shifts the low chunk has
    // reached bit 0 and the result is fully aligned.
    res_next = WIDTH'({chunk[BITS_PER_CYCLE-1:0], res_q} >> BITS_PER_CYCLE);
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the chunk MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  logic msb_cin;
  always_comb begin
    msb_cin = a_q[BITS_PER_CYCLE-1] ^ b_q[BITS_PER_CYCLE-1] ^ chunk[BITS_PER_CYCLE-1];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      res_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            // Subtract as a + ~b + 1; cin is not used for subtraction.
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> BITS_PER_CYCLE;
          b_q   <= b_q >> BITS_PER_CYCLE;
          carry <= chunk[BITS_PER_CYCLE];
          res_q <= res_next;
          if (cnt == '0) begin
            sum   <= res_next;
            cout  <= chunk[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= msb_cin ^ chunk[BITS_PER_CYCLE];
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 with
//   BITS_PER_CYCLE = 1, 4 and 8. Each accepted start pushes the hand-computed
//   result and expected done cycle; a monitor pops on every done pulse.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sub = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic       cin = 1'b0;
  logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic       busy1, busy4, busy8;
  logic       done1, done4, done8;
  logic [7:0] sum1, sum4, sum8;
  logic       cout1, cout4, cout8;
  logic       ovf1, ovf4, ovf8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf1 = 1'b0;
  assign ovf4 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  task automatic check(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic get_busy(input int d);
    case (d)
      1:       return busy1;
      4:       return busy4;
      default: return busy8;
    endcase
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      1:       start1 = v;
      4:       start4 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      1:       q1.push_back(e);
      4:       q4.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  // Monitor side of the scoreboard: one pop per done pulse.
  task automatic mon(input int d, input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    logic have = 1'b0;
    case (d)
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      4: if (q4.size() > 0) begin e = q4.pop_front(); have = 1'b1; end
      default: if (q8.size() > 0) begin e = q8.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_done_bpc%0d: got done=1 at cycle %0d, expected none", d, cyc);
    end else begin
      check($sformatf("sum_bpc%0d", d), int'(s), int'(e.sum));
      check($sformatf("cout_bpc%0d", d), int'(c), int'(e.cout));
      check($sformatf("done_cycle_bpc%0d", d), cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("ovf_bpc%0d", d), int'(o), int'(e.ovf));
`else
      if (o) $display("note: ovf tie-off high");
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done1) mon(1, sum1, cout1, ovf1);
      if (done4) mon(4, sum4, cout4, ovf4);
      if (done8) mon(8, sum8, cout8, ovf8);
    end
  end

  // Wait (bounded) for the DUT to accept, then present one operation.
  task automatic issue(input int d, input logic s, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!get_busy(d)) begin ok = 1'b1; break; end
    end
    if (!ok) check($sformatf("idle_timeout_bpc%0d", d), 1, 0);
    sub = s; a = va; b = vb; cin = vc;
    set_start(d, 1'b1);
    @(posedge clk);
    #1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 8 / d;
    push(d, e);
    set_start(d, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && q8.size() == 0 && !busy1 && !busy4 && !busy8) break;
    end
  endtask

  initial begin
    int         k;
    int         busy_cnt;
    logic       hold_ok;
    logic [7:0] prev;

    // Reset state
    #1;
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_sum", int'(sum1), 0);
    check("rst_cout", int'(cout1), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 0x5A + 0x3C: busy exactly 8 cycles, sum never shows partials
    issue(1, 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    busy_cnt = 0;
    hold_ok  = 1'b1;
    prev     = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1) break;
      if (busy1) busy_cnt++;
      if (sum1 != prev) hold_ok = 1'b0;
    end
    check("busy_cycles", busy_cnt, 8);
    check("sum_held_during_run", int'(hold_ok), 1);

    issue(1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(1, 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    // Subtracts with cin=1, which must be ignored
    issue(1, 1'b1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
    issue(1, 1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
    issue(1, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    drain();

    // Start held high through RUN with operands changed mid-operation
    @(negedge clk);
    sub = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    q1.push_back('{sum: 8'h33, cout: 1'b0, ovf: 1'b0, cyc: k + 8});
    q1.push_back('{sum: 8'h45, cout: 1'b0, ovf: 1'b0, cyc: k + 17});
    repeat (3) @(negedge clk);
    a = 8'h40; b = 8'h05;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (cyc >= k + 9) break;
    end
    start1 = 1'b0;
    drain();

    // Reset during RUN cycle 3 aborts with no done pulse
    @(negedge clk);
    sub = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy1), 0);
    check("abort_done", int'(done1), 0);
    check("abort_sum", int'(sum1), 0);
    check("abort_cout", int'(cout1), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done_sum_held", int'(sum1), 0);
    issue(1, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Wider chunks: 2 RUN cycles and 1 RUN cycle
    issue(4, 1'b0, 8'h9C, 8'h77, 1'b1, 8'h14, 1'b1, 1'b0);
    issue(4, 1'b1, 8'h50, 8'h70, 1'b0, 8'hE0, 1'b0, 1'b0);
    issue(8, 1'b0, 8'h9C, 8'h77, 1'b1, 8'h14, 1'b1, 1'b0);
    issue(8, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drain();

    check("pending_bpc1", q1.size(), 0);
    check("pending_bpc4", q4.size(), 0);
    check("pending_bpc8", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the team's single-bit full adder cell. It adds or subtracts two WIDTH-bit operands BITS_PER_CYCLE bits per clock, rippling the carry through a registered carry flop. A start/busy/done handshake lets it sit between a small controller and a result register. Area and latency trade off through BITS_PER_CYCLE.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
BITS_PER_CYCLE, 1, bits processed per RUN cycle; must divide WIDTH exactly, otherwise elaboration fails via $error.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = a+b+cin, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in for add; ignored when sub=1
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when sum/cout are valid
sum  output  WIDTH  result; held until the next accepted start
cout  output  1  final carry; for sub, 1 = no borrow

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, sum=0, cout=0, internal operand and carry registers=0. Reset mid-RUN aborts the operation and produces no done pulse.
- N = WIDTH/BITS_PER_CYCLE.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Capture A=a and B=(sub ? ~b : b).
  - Initialise carry = (sub ? 1 : cin).
  - Load cycle counter with N-1 and go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Add the low BITS_PER_CYCLE bits of A and B plus carry.
  - Shift A and B right by BITS_PER_CYCLE.
  - Shift the partial sum into the result register from the MSB end.
  - Update carry with the chunk carry-out.
  - Decrement the counter. On the edge where counter==0, write sum, write cout=carry-out and go to DONE.
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 is accepted exactly as in IDLE and goes to RUN, so back-to-back operations have a 1-cycle bubble.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k gives done=1 during the cycle after edge k+N.
- busy is high during RUN cycles only.
- sum and cout keep their last values through IDLE and are updated only on the final RUN edge. The result register is internal, so partial results never appear on sum.
- start while busy=1 is ignored, and input changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.
- WIDTH=BITS_PER_CYCLE (N=1) is legal: one RUN cycle.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow = carry into MSB XOR carry out of MSB, taken on the final chunk.
  - ovf reset value 0.
  - Written together with sum/cout and held likewise.
  - Valid for both add and sub.
- Undefined: port ovf does not exist, and no MSB carry-in tracking logic is generated.

Test Plan:
- WIDTH=8, BPC=1: a=0x5A, b=0x3C, cin=0, sub=0, start at edge k -> busy high for 8 cycles, done pulse after edge k+8, sum=0x96, cout=0; with OVF_EN, ovf=1.
- WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, BPC=1, sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1. Then a=0x00, b=0x01 -> sum=0xFF, cout=0, ovf=0. Check cin=1 is ignored in both.
- Start held high continuously during RUN, with a/b changed mid-operation -> result reflects only the first captured operands. The second op is accepted in DONE; the next done follows exactly N+1 cycles after the previous one.
- Assert rst at RUN cycle 3, then release -> busy=0, done never pulses, sum=0, cout=0. A subsequent 0x01+0x01 gives 0x02.
- WIDTH=8, BPC=4: a=0x9C, b=0x77, cin=1 -> done after 2 RUN cycles, sum=0x14, cout=1. WIDTH=8, BPC=8: same operands -> 1 RUN cycle, same result.
